// File: rtl/if2_fetch_ctrl_if.sv
// IF2 fetch-stage bundle: IF1 slot, icache lookup/refill, memory refill port, IF2/ID slot.
// The master side is the fetch controller; the slave side is the surrounding pipeline/memory.
interface if2_fetch_ctrl_if;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic        if1_branch_bp;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        id_allow_in;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        refill_we;
  logic [31:0] refill_addr;
  logic [31:0] refill_data;
  logic [31:0] if2_pc;
  logic [31:0] if2_inst;
  logic        if2_icache_hit;
  logic        if2_branch_bp;
  logic        if1_if2_cache_valid;
  logic        if2_ready;

  modport master (
    input  if1_valid, if1_pc, if1_branch_bp, cache_hit, cache_rdata,
           id_allow_in, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output mem_req, mem_addr, refill_we, refill_addr, refill_data,
           if2_pc, if2_inst, if2_icache_hit, if2_branch_bp, if1_if2_cache_valid, if2_ready
  );

  modport slave (
    output if1_valid, if1_pc, if1_branch_bp, cache_hit, cache_rdata,
           id_allow_in, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  mem_req, mem_addr, refill_we, refill_addr, refill_data,
           if2_pc, if2_inst, if2_icache_hit, if2_branch_bp, if1_if2_cache_valid, if2_ready
  );
endinterface

// File: rtl/if2_fetch_ctrl.sv
// IF2 fetch slot with single-outstanding icache miss refill; hits pass through in 0 cycles.
// Slot stalls (if2_ready=0) during a refill or while ID refuses the slot; flush kills slot and refill.
module if2_fetch_ctrl (
  input logic           clk,
  input logic           rst_n,
  if2_fetch_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DROP} state_t;

  state_t      state, state_nxt;
  logic        slot_vld;
  logic [31:0] slot_pc;
  logic        slot_bp;
  logic [31:0] buf_dat;
  logic [31:0] req_addr;
  logic        refill_we_q;
  logic [31:0] refill_addr_q;
  logic [31:0] refill_dat_q;
  logic        resp_take;
  logic        idle_hit;

  assign resp_take = bus.mem_resp_valid && (state == WAIT || state == DROP);
  assign idle_hit  = (state == IDLE) && slot_vld && bus.cache_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (slot_vld && !bus.cache_hit && !bus.flush) state_nxt = REQ;
      REQ: begin
        // a flush coinciding with acceptance still leaves a response in flight
        if (bus.flush)              state_nxt = bus.mem_req_ready ? DROP : IDLE;
        else if (bus.mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid && bus.flush) state_nxt = IDLE;
        else if (bus.mem_resp_valid)         state_nxt = DONE;
        else if (bus.flush)                  state_nxt = DROP;
      end
      DONE: if (bus.flush || bus.id_allow_in) state_nxt = IDLE;
      DROP: if (bus.mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req             = (state == REQ);
    bus.mem_addr            = (state == REQ) ? slot_pc : 32'd0;
    bus.if2_pc              = slot_pc;
    bus.if2_branch_bp       = slot_bp;
    bus.if2_inst            = (state == DONE) ? buf_dat : bus.cache_rdata;
    bus.if2_icache_hit      = idle_hit;
    bus.if1_if2_cache_valid = slot_vld && !bus.flush && (idle_hit || state == DONE);
    bus.if2_ready           = bus.flush
                            || ((state == IDLE) && (!slot_vld || (bus.cache_hit && bus.id_allow_in)))
                            || ((state == DONE) && bus.id_allow_in);
    bus.refill_we           = refill_we_q;
    bus.refill_addr         = refill_addr_q;
    bus.refill_data         = refill_dat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld      <= 1'b0;
      slot_pc       <= 32'd0;
      slot_bp       <= 1'b0;
      buf_dat       <= 32'd0;
      req_addr      <= 32'd0;
      refill_we_q   <= 1'b0;
      refill_addr_q <= 32'd0;
      refill_dat_q  <= 32'd0;
    end else begin
      refill_we_q <= resp_take;
      if (resp_take) begin
        refill_addr_q <= req_addr;
        refill_dat_q  <= bus.mem_resp_data;
      end
      if (state == REQ && bus.mem_req_ready) req_addr <= slot_pc;
      if (state == WAIT && bus.mem_resp_valid) buf_dat <= bus.mem_resp_data;
      if (bus.flush) begin
        slot_vld <= 1'b0;
      end else if (bus.if2_ready) begin
        slot_vld <= bus.if1_valid;
        slot_pc  <= bus.if1_pc;
        slot_bp  <= bus.if1_branch_bp;
      end
    end
  end
endmodule

// File: tb/tb_if2_fetch_ctrl.sv
// Fetch-slot scoreboard bench: a memory image plus a behavioural icache predict every delivered
// slot and every refill write; directed miss/stall/flush/reset sequences, then random traffic.
module tb_if2_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if2_fetch_ctrl_if bus ();
  if2_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {logic [31:0] pc; logic [31:0] inst; logic bp;} slot_t;
  typedef struct {logic [31:0] addr; int dly; bit orphan;} pend_t;
  typedef struct {logic [31:0] addr; logic [31:0] dat;} wr_t;

  slot_t       exp_q[$];
  pend_t       pend_q[$];
  wr_t         refill_q[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] tb_cache [logic [31:0]];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_deliv = 0;

  logic        d_if1_valid, d_bp, d_flush, d_allow, d_ready, d_rst_n;
  logic [31:0] d_pc;
  int          d_dly;

  slot_t       m_e;
  wr_t         m_w;
  logic        prev_hold;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // One clock of environment: drive inputs, answer memory, look up the icache, predict the edge.
  task automatic cycle();
    pend_t p;
    int    n;
    @(negedge clk);
    rst_n              = d_rst_n;
    bus.if1_valid      = d_if1_valid;
    bus.if1_pc         = d_pc;
    bus.if1_branch_bp  = d_bp;
    bus.flush          = d_flush;
    bus.id_allow_in    = d_allow;
    bus.mem_req_ready  = d_ready;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = $urandom;
    if (pend_q.size() > 0) begin
      p = pend_q.pop_front();
      if (p.dly == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_word(p.addr);
        if (!p.orphan) refill_q.push_back('{p.addr, mem_word(p.addr)});
      end else begin
        p.dly = p.dly - 1;
        pend_q.push_front(p);
      end
    end
    bus.cache_hit   = tb_cache.exists(bus.if2_pc);
    bus.cache_rdata = bus.cache_hit ? tb_cache[bus.if2_pc] : $urandom;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      refill_q.delete();
      n = pend_q.size();
      for (int i = 0; i < n; i++) begin
        p = pend_q.pop_front();
        p.orphan = 1'b1;
        pend_q.push_back(p);
      end
    end else begin
      if (bus.flush) exp_q.delete();
      else if (bus.if2_ready && bus.if1_valid)
        exp_q.push_back('{bus.if1_pc, mem_word(bus.if1_pc), bus.if1_branch_bp});
      if (bus.mem_req && bus.mem_req_ready) begin
        chk("one_outstanding", pend_q.size(), 0);
        pend_q.push_back('{bus.mem_addr, d_dly, 1'b0});
      end
    end
  endtask

  // Monitor: consumes delivered slots and refill writes independently of the stimulus.
  initial begin
    prev_hold = 1'b0;
    prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (bus.if1_if2_cache_valid && bus.id_allow_in) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_delivery: got pc %h, required no slot", bus.if2_pc);
          end else begin
            m_e = exp_q.pop_front();
            chk("deliver_pc", bus.if2_pc, m_e.pc);
            chk("deliver_inst", bus.if2_inst, m_e.inst);
            chk("deliver_bp", {31'd0, bus.if2_branch_bp}, {31'd0, m_e.bp});
          end
        end
        if (bus.refill_we) begin
          if (refill_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_refill: got addr %h, required no write", bus.refill_addr);
          end else begin
            m_w = refill_q.pop_front();
            chk("refill_addr", bus.refill_addr, m_w.addr);
            chk("refill_data", bus.refill_data, m_w.dat);
            tb_cache[m_w.addr] = m_w.dat;
          end
        end
        if (prev_hold) begin
          chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
          chk("mem_addr_held", bus.mem_addr, prev_addr);
        end
        prev_hold = bus.mem_req && !bus.mem_req_ready && !bus.flush;
        prev_addr = bus.mem_addr;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    int n_we;
    logic [31:0] held_inst;
    rst_n = 1'b0;
    bus.if1_valid = 1'b0; bus.if1_pc = '0; bus.if1_branch_bp = 1'b0;
    bus.cache_hit = 1'b0; bus.cache_rdata = '0; bus.id_allow_in = 1'b0; bus.flush = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    d_rst_n = 1'b0; d_if1_valid = 1'b0; d_pc = '0; d_bp = 1'b0; d_flush = 1'b0;
    d_allow = 1'b1; d_ready = 1'b0; d_dly = 1;
    mem_img[32'h1C00_0010] = 32'h0280_0421;
    mem_img[32'h1C00_0020] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) tb_cache[32'h1C00_0000 + 4 * k] = mem_word(32'h1C00_0000 + 4 * k);

    cycle(); cycle();
    d_rst_n = 1'b1;
    cycle();
    chk("reset_cache_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd0);
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_refill_we", {31'd0, bus.refill_we}, 32'd0);
    chk("reset_if2_pc", bus.if2_pc, 32'd0);
    chk("reset_if2_ready", {31'd0, bus.if2_ready}, 32'd1);

    // hit stream, ending by loading the miss PC 0x1C000010
    for (int k = 0; k < 5; k++) begin
      d_if1_valid = 1'b1; d_pc = 32'h1C00_0000 + 4 * k; d_bp = (k % 2 == 1);
      cycle();
      if (k > 0) begin
        chk("hit_stream_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd1);
        chk("hit_stream_hit", {31'd0, bus.if2_icache_hit}, 32'd1);
        chk("hit_stream_ready", {31'd0, bus.if2_ready}, 32'd1);
      end
    end
    d_if1_valid = 1'b0;

    // miss: accept after 2 cycles, response 3 later, then 4-cycle downstream stall
    d_dly = 2; n_we = 0; held_inst = '0;
    for (int i = 0; i < 13; i++) begin
      d_ready = (i == 3);
      d_allow = !(i >= 7 && i <= 10);
      cycle();
      if (i >= 4) n_we += int'(bus.refill_we);
      if (i == 0) begin
        chk("miss_idle_req", {31'd0, bus.mem_req}, 32'd0);
        chk("miss_idle_ready", {31'd0, bus.if2_ready}, 32'd0);
      end
      if (i == 1) begin
        chk("miss_mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("miss_mem_addr", bus.mem_addr, 32'h1C00_0010);
      end
      if (i == 7) begin
        chk("miss_refill_we", {31'd0, bus.refill_we}, 32'd1);
        chk("miss_refill_addr", bus.refill_addr, 32'h1C00_0010);
        chk("miss_refill_data", bus.refill_data, 32'h0280_0421);
        chk("miss_inst", bus.if2_inst, 32'h0280_0421);
        chk("miss_hit_flag", {31'd0, bus.if2_icache_hit}, 32'd0);
        held_inst = bus.if2_inst;
      end
      if (i >= 7 && i <= 10) begin
        chk("stall_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd1);
        chk("stall_inst", bus.if2_inst, held_inst);
        chk("stall_pc", bus.if2_pc, 32'h1C00_0010);
        chk("stall_ready", {31'd0, bus.if2_ready}, 32'd0);
      end
      if (i == 11) chk("release_ready", {31'd0, bus.if2_ready}, 32'd1);
      if (i == 12) chk("release_idle_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd0);
    end
    chk("miss_refill_pulses", n_we, 32'd1);

    // flush while waiting for the response
    d_dly = 3; d_allow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d_if1_valid = (i == 0); d_pc = 32'h1C00_0020; d_bp = 1'b0;
      d_ready = (i == 2); d_flush = (i == 3);
      cycle();
      if (i >= 3) chk("drop_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd0);
      if (i == 4) chk("drop_ready", {31'd0, bus.if2_ready}, 32'd0);
      if (i == 6) chk("drop_no_early_we", {31'd0, bus.refill_we}, 32'd0);
      if (i == 7) begin
        chk("drop_refill_we", {31'd0, bus.refill_we}, 32'd1);
        chk("drop_refill_addr", bus.refill_addr, 32'h1C00_0020);
        chk("drop_refill_data", bus.refill_data, 32'hDEAD_BEEF);
        chk("drop_back_idle", {31'd0, bus.if2_ready}, 32'd1);
      end
    end

    // flush in REQ before acceptance
    for (int i = 0; i < 7; i++) begin
      d_if1_valid = (i == 0); d_pc = 32'h1C00_0030;
      d_ready = 1'b0; d_flush = (i == 2);
      cycle();
      if (i == 2) chk("reqflush_req_before", {31'd0, bus.mem_req}, 32'd1);
      if (i == 3) begin
        chk("reqflush_req_after", {31'd0, bus.mem_req}, 32'd0);
        chk("reqflush_ready", {31'd0, bus.if2_ready}, 32'd1);
      end
      if (i >= 3) chk("reqflush_no_refill", {31'd0, bus.refill_we}, 32'd0);
    end
    chk("reqflush_no_request", pend_q.size(), 32'd0);
    d_flush = 1'b0;

    // reset while waiting; late response must not refill
    d_dly = 2;
    for (int i = 0; i < 9; i++) begin
      d_if1_valid = (i == 0); d_pc = 32'h1C00_0040; d_bp = 1'b1;
      d_ready = (i == 2); d_rst_n = (i != 3);
      cycle();
      if (i == 4) begin
        chk("rstwait_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rstwait_mem_addr", bus.mem_addr, 32'd0);
        chk("rstwait_valid", {31'd0, bus.if1_if2_cache_valid}, 32'd0);
        chk("rstwait_pc", bus.if2_pc, 32'd0);
        chk("rstwait_bp", {31'd0, bus.if2_branch_bp}, 32'd0);
        chk("rstwait_hit", {31'd0, bus.if2_icache_hit}, 32'd0);
      end
      if (i >= 4) chk("rstwait_no_refill", {31'd0, bus.refill_we}, 32'd0);
    end

    // random traffic over a small PC set so hits and misses both recur
    for (int n = 0; n < 3000; n++) begin
      d_if1_valid = ($urandom % 4) != 0;
      d_pc        = 32'h1C00_0000 + 32'($urandom_range(0, 15)) * 4;
      d_bp        = 1'($urandom % 2);
      d_flush     = ($urandom % 20) == 0;
      d_allow     = ($urandom % 4) != 0;
      d_ready     = 1'($urandom % 2);
      d_dly       = $urandom_range(0, 3);
      cycle();
    end
    d_if1_valid = 1'b0; d_flush = 1'b0; d_allow = 1'b1; d_ready = 1'b1;
    for (int n = 0; n < 40; n++) cycle();
    chk("drain_slots", exp_q.size(), 32'd0);
    chk("drain_refills", refill_q.size(), 32'd0);
    chk("drain_pending", pend_q.size(), 32'd0);
    chk("deliveries_seen", {31'd0, n_deliv > 200}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/if2_fetch_ctrl.md
IF2_FETCH_CTRL -- requirements
Module: if2_fetch_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL: if1_valid, if1_pc[31:0], if1_branch_bp  in  1/32/1  IF1 fetch slot.
REQ-004 SHALL: cache_hit, cache_rdata[31:0]  in  1/32  icache lookup result for the PC held in IF2, same cycle.
REQ-005 SHALL: id_allow_in  in  1  downstream IF2/ID register write enable; 1 = slot accepted this edge.
REQ-006 SHALL: flush  in  1  kill IF2 content and any pending refill.
REQ-007 SHALL: mem_req, mem_addr[31:0]  out  1/32  refill read request; mem_req_ready  in  1.
REQ-008 SHALL: mem_resp_valid, mem_resp_data[31:0]  in  1/32  refill response, one word, always accepted.
REQ-009 SHALL: refill_we, refill_addr[31:0], refill_data[31:0]  out  1/32/32  icache word write.
REQ-010 SHALL: if2_pc, if2_inst, if2_icache_hit, if2_branch_bp, if1_if2_cache_valid  out  32/32/1/1/1  slot to IF2/ID register.
REQ-011 SHALL: if2_ready  out  1  IF1 may advance into IF2 this edge.

Function
REQ-012 SHALL hold an IF2 slot (valid, pc, bp); loaded from IF1 on edge with if2_ready=1 and flush=0 (valid <= if1_valid); cleared on flush.
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE, DROP; reset state IDLE.
REQ-014 IDLE: slot valid and cache_hit=0 and flush=0 -> REQ next edge.
REQ-015 REQ: mem_req=1, mem_addr=if2_pc (held stable); mem_req_ready=1 -> WAIT; flush before acceptance -> IDLE with no request issued that edge onward.
REQ-016 WAIT: mem_resp_valid=1 -> DONE, capture mem_resp_data into buffer; flush -> DROP.
REQ-017 Response in WAIT or DROP SHALL pulse refill_we for exactly one cycle (next cycle), refill_addr=requested PC, refill_data=response word.
REQ-018 DONE: id_allow_in=1 -> IDLE; flush -> IDLE.
REQ-019 DROP: mem_resp_valid=1 -> IDLE; slot output suppressed throughout.
REQ-020 if1_if2_cache_valid SHALL be 1 iff slot valid, flush=0, and (IDLE with cache_hit=1, or DONE).
REQ-021 if2_inst SHALL be buffer in DONE, else cache_rdata; if2_icache_hit SHALL be 1 only in IDLE with cache_hit=1; if2_pc/if2_branch_bp SHALL reflect slot.
REQ-022 if2_ready SHALL be 1 iff flush=1, or IDLE and (slot invalid or (cache_hit=1 and id_allow_in=1)), or DONE and id_allow_in=1; 0 in REQ/WAIT/DROP otherwise.
REQ-023 At most one refill outstanding; mem_req SHALL be 0 in all states except REQ.
REQ-024 Flush and mem_resp_valid in same WAIT cycle: refill write still performed, state -> IDLE, slot cleared.
REQ-025 Slot held unchanged while id_allow_in=0 (downstream stall); outputs stable across stall.

Reset
REQ-026 rst_n=0 at edge: state IDLE, slot valid 0, pc/bp/buffer 0, mem_req 0, refill_we 0, if1_if2_cache_valid 0; reset mid-refill abandons request, late mem_resp_valid after reset ignored (no refill_we).

Verification
REQ-027 Hit stream: if1_pc 0x1C000000, 0x1C000004, cache_hit=1, id_allow_in=1 -> if1_if2_cache_valid=1 each cycle, if2_icache_hit=1, zero bubbles.
REQ-028 Miss: pc 0x1C000010, cache_hit=0, mem_req_ready after 2 cycles, resp 0x02800421 after 3 more -> mem_addr=0x1C000010, refill_we one cycle, DONE outputs if2_inst=0x02800421, hit=0.
REQ-029 Downstream stall in DONE: id_allow_in=0 for 4 cycles -> if2_inst/if2_pc stable, if2_ready=0; release -> one accept, IDLE.
REQ-030 Flush in WAIT: then resp 0xDEADBEEF -> DROP, refill_we pulse with 0xDEADBEEF, if1_if2_cache_valid stays 0, return IDLE.
REQ-031 Flush in REQ with mem_req_ready=0 -> mem_req drops next cycle, no response expected, IDLE.
REQ-032 Reset asserted in WAIT -> all outputs 0 next cycle; subsequent mem_resp_valid produces no refill_we.
